spi_mem_arbiter: RTL

Sequences the single-port synchronous RAM behind the SPI slave. Decodes the 10-bit command words the SPI slave delivers on `rx_data`/`rx_valid` into address-latch, write and read operations. Arbitrates RAM access between that SPI command stream and a local host port. Returns SPI read data on `tx_data`/`tx_valid` for the parallel-to-serial MISO path.

---
 rtl/spi_mem_pkg.sv | 21 ++
 rtl/spi_mem_arbiter_rr_arb2.sv | 54 +++++
 rtl/spi_mem_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI-side RAM sequencer: command codes carried in
// bits [DATA_W+1:DATA_W] of each SPI word and the sequencer state encoding.
package spi_mem_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPI_RD  = 2'd1,
        HOST_RD = 2'd2
    } state_e;

    // Only WR_DATA and RD_DATA occupy the pending slot; both have bit 0 set.
    function automatic logic is_mem_cmd(input logic [1:0] cmd);
        return cmd[0];
    endfunction

endpackage

// File: rtl/spi_mem_arbiter_rr_arb2.sv
// Two-requester arbiter (SPI slot vs host) with a round-robin pointer.
// Build option SPI_MEM_FIXED_PRIO_EN: SPI always wins and the pointer is removed.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_spi_i,
    input  logic req_host_i,
    output logic gnt_spi_o,
    output logic gnt_host_o
);

`ifdef SPI_MEM_FIXED_PRIO_EN

    always_comb begin
        gnt_spi_o  = en_i && req_spi_i;
        gnt_host_o = en_i && req_host_i && !req_spi_i;
    end

`else

    // 1: the host is favoured on the next contested cycle.
    logic prio_host_q;
    logic prio_host_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_host_q <= 1'b0;
        end else begin
            prio_host_q <= prio_host_d;
        end
    end

    always_comb begin
        gnt_spi_o  = 1'b0;
        gnt_host_o = 1'b0;
        if (en_i) begin
            if (req_spi_i && (!req_host_i || !prio_host_q)) begin
                gnt_spi_o = 1'b1;
            end else if (req_host_i) begin
                gnt_host_o = 1'b1;
            end
        end
        prio_host_d = prio_host_q;
        if (gnt_spi_o) begin
            prio_host_d = 1'b1;
        end else if (gnt_host_o) begin
            prio_host_d = 1'b0;
        end
    end

`endif

endmodule

// File: rtl/spi_mem_arbiter.sv
// Decodes SPI command words into RAM accesses and shares the single-port RAM
// with a host port. Build option: SPI_MEM_FIXED_PRIO_EN (SPI always wins).
//
//   state   | meaning
//   IDLE    | arbitrate pending SPI slot vs host, issue winner combinationally
//   SPI_RD  | RAM data for an SPI read is on mem_rdata; capture into tx_data
//   HOST_RD | RAM data for a host read is on mem_rdata; capture into host_rdata
module spi_mem_arbiter
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W+1:0] rx_data,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_ovf,
    output logic              err_seq
);

    state_e state_q, state_d;

    logic              slot_vld_q,   slot_vld_d;
    logic              slot_we_q,    slot_we_d;
    logic [ADDR_W-1:0] slot_addr_q,  slot_addr_d;
    logic [DATA_W-1:0] slot_wdata_q, slot_wdata_d;

    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
    logic              rd_armed_q, rd_armed_d;

    logic              tx_valid_q,    tx_valid_d;
    logic [DATA_W-1:0] tx_data_q,     tx_data_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0] host_rdata_q,  host_rdata_d;
    logic              err_ovf_q,     err_ovf_d;
    logic              err_seq_q,     err_seq_d;

    logic [1:0]        cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] pl_addr;
    logic              gnt_spi;
    logic              gnt_host;
    logic              slot_free;

    assign cmd     = rx_data[DATA_W+1:DATA_W];
    assign payload = rx_data[DATA_W-1:0];
    assign pl_addr = ADDR_W'(payload);

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .en_i       (state_q == IDLE),
        .req_spi_i  (slot_vld_q),
        .req_host_i (host_req),
        .gnt_spi_o  (gnt_spi),
        .gnt_host_o (gnt_host)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_spi && !slot_we_q) begin
                    state_d = SPI_RD;
                end else if (gnt_host && !host_we) begin
                    state_d = HOST_RD;
                end
            end
            SPI_RD:  state_d = IDLE;
            HOST_RD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        host_gnt  = 1'b0;
        if (gnt_spi) begin
            mem_en    = 1'b1;
            mem_we    = slot_we_q;
            mem_addr  = slot_addr_q;
            mem_wdata = slot_wdata_q;
        end else if (gnt_host) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            host_gnt  = 1'b1;
        end
    end

    // An issuing slot is freed before decode, so a same-cycle command can reload it.
    assign slot_free = !slot_vld_q || gnt_spi;

    always_comb begin
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        rd_armed_d   = rd_armed_q;
        slot_vld_d   = slot_vld_q && !gnt_spi;
        slot_we_d    = slot_we_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        err_ovf_d    = 1'b0;
        err_seq_d    = 1'b0;
        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr_d = pl_addr;
                CMD_RD_ADDR: begin
                    rd_addr_d  = pl_addr;
                    rd_armed_d = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (slot_free) begin
                        slot_vld_d   = 1'b1;
                        slot_we_d    = 1'b1;
                        slot_addr_d  = wr_addr_q;
                        slot_wdata_d = payload;
                    end
                end
                CMD_RD_DATA: begin
                    if (!rd_armed_q) begin
                        err_seq_d = 1'b1;
                    end else if (slot_free) begin
                        slot_vld_d   = 1'b1;
                        slot_we_d    = 1'b0;
                        slot_addr_d  = rd_addr_q;
                        slot_wdata_d = '0;
                        rd_armed_d   = 1'b0;
                    end
                end
                default: ;
            endcase
            if (is_mem_cmd(cmd) && !slot_free && !(cmd == CMD_RD_DATA && !rd_armed_q)) begin
                err_ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        tx_valid_d    = (state_q == SPI_RD);
        tx_data_d     = (state_q == SPI_RD) ? mem_rdata : tx_data_q;
        host_rvalid_d = (state_q == HOST_RD);
        host_rdata_d  = (state_q == HOST_RD) ? mem_rdata : host_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q    <= 1'b0;
            slot_we_q     <= 1'b0;
            slot_addr_q   <= '0;
            slot_wdata_q  <= '0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            rd_armed_q    <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            err_ovf_q     <= 1'b0;
            err_seq_q     <= 1'b0;
        end else begin
            slot_vld_q    <= slot_vld_d;
            slot_we_q     <= slot_we_d;
            slot_addr_q   <= slot_addr_d;
            slot_wdata_q  <= slot_wdata_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            rd_armed_q    <= rd_armed_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            err_ovf_q     <= err_ovf_d;
            err_seq_q     <= err_seq_d;
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign err_ovf     = err_ovf_q;
    assign err_seq     = err_seq_q;

endmodule
